// File: rtl/core_ctrl_pkg.sv
// Shared types for the core pipeline sequencing logic: FSM states, the
// hard-wired zero register index and the per-stage register control bundle.
package core_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_hold;
    logic id_ex_bubble;
    logic ex_mem_hold;
    logic mem_wb_bubble;
  } stage_ctrl_t;

endpackage

// File: rtl/core_load_use_detect.sv
// Load-use comparator: the load in EX writes a register the ID instruction
// reads. r0 never carries a dependency.
module core_load_use_detect
  import core_ctrl_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       ex_mem_memread,
  input  logic [4:0] ex_reg_rt,
  output logic       load_use
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit   = id_uses_rs && (id_rs == ex_reg_rt);
  assign rt_hit   = id_uses_rt && (id_rt == ex_reg_rt);
  assign load_use = ex_mem_memread && (ex_reg_rt != REG_ZERO) && (rs_hit || rt_hit);

endmodule

// File: rtl/core_hazard_ctrl.sv
// Pipeline sequencing controller: per-cycle advance/hold/bubble decisions for
// load-use, branch flush and multi-cycle memory access, with stuck-access timeout.
module core_hazard_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 16
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_mem_memread,
  input  logic [4:0]       ex_reg_rt,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_hold,
  output logic             id_ex_bubble,
  output logic             ex_mem_hold,
  output logic             mem_wb_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_e            state;
  state_e            state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_cnt_nxt;
  logic              load_use;
  logic              freeze;
  stage_ctrl_t       ctrl;

  core_load_use_detect u_load_use (
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_uses_rs     (id_uses_rs),
    .id_uses_rt     (id_uses_rt),
    .ex_mem_memread (ex_mem_memread),
    .ex_reg_rt      (ex_reg_rt),
    .load_use       (load_use)
  );

  assign freeze = ((state == RUN)  && mem_req && !mem_ack) ||
                  ((state == WAIT) && !mem_ack) ||
                  (state == ERR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (!ctrl.pc_write && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  // wait_cnt counts frozen cycles already spent on the outstanding access
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      RUN: begin
        if (mem_req && !mem_ack) begin
          if (TIMEOUT == 1) begin
            state_nxt = ERR;
          end else begin
            state_nxt    = WAIT;
            wait_cnt_nxt = WAIT_W'(1);
          end
        end
      end
      WAIT: begin
        if (mem_ack) begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else if ((TIMEOUT != 0) && (wait_cnt == WAIT_LAST)) begin
          state_nxt = ERR;
        end else begin
          wait_cnt_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      ERR:     state_nxt = ERR;
      default: state_nxt = RUN;
    endcase
  end

  // A frozen cycle defers branch and load-use; they re-evaluate once it lifts
  always_comb begin
    ctrl = '{pc_write: 1'b1, if_id_write: 1'b1, default: 1'b0};
    if (rst) begin
      ctrl.pc_write      = 1'b0;
      ctrl.if_id_write   = 1'b0;
      ctrl.if_id_flush   = 1'b1;
      ctrl.id_ex_bubble  = 1'b1;
      ctrl.mem_wb_bubble = 1'b1;
    end else if (freeze) begin
      ctrl.pc_write      = 1'b0;
      ctrl.if_id_write   = 1'b0;
      ctrl.id_ex_hold    = 1'b1;
      ctrl.ex_mem_hold   = 1'b1;
      ctrl.mem_wb_bubble = 1'b1;
    end else if (branch_taken) begin
      ctrl.if_id_flush  = 1'b1;
      ctrl.id_ex_bubble = 1'b1;
    end else if (load_use) begin
      ctrl.pc_write     = 1'b0;
      ctrl.if_id_write  = 1'b0;
      ctrl.id_ex_bubble = 1'b1;
    end
  end

  assign pc_write      = ctrl.pc_write;
  assign if_id_write   = ctrl.if_id_write;
  assign if_id_flush   = ctrl.if_id_flush;
  assign id_ex_hold    = ctrl.id_ex_hold;
  assign id_ex_bubble  = ctrl.id_ex_bubble;
  assign ex_mem_hold   = ctrl.ex_mem_hold;
  assign mem_wb_bubble = ctrl.mem_wb_bubble;
  assign mem_timeout   = (state == ERR);

endmodule

// File: tb/tb_core_hazard_ctrl.sv
// Bench for core_hazard_ctrl: directed vector table, hand-written memory/timeout
// sequences and randomized traffic against a frozen-cycle-counting reference model.
module tb_core_hazard_ctrl;

  localparam int TO = 4;

  // {pc_write, if_id_write, if_id_flush, id_ex_hold, id_ex_bubble, ex_mem_hold, mem_wb_bubble}
  localparam logic [6:0] C_RST = 7'b0010101;
  localparam logic [6:0] C_FRZ = 7'b0001011;
  localparam logic [6:0] C_BR  = 7'b1110100;
  localparam logic [6:0] C_LU  = 7'b0000100;
  localparam logic [6:0] C_ADV = 7'b1100000;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_reg_rt;
  logic        id_uses_rs, id_uses_rt, ex_mem_memread, branch_taken, mem_req, mem_ack;
  logic        pc_write, if_id_write, if_id_flush, id_ex_hold, id_ex_bubble;
  logic        ex_mem_hold, mem_wb_bubble, mem_timeout;
  logic [15:0] stall_cnt;
  logic        s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_hold, s_id_ex_bubble;
  logic        s_ex_mem_hold, s_mem_wb_bubble, s_mem_timeout;
  logic [1:0]  s_stall_cnt;
  logic [6:0]  act;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state
  bit m_err;
  int m_frozen;
  int m_stall;
  int m_stall2;

  always #5 clk = ~clk;

  core_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_mem_memread(ex_mem_memread), .ex_reg_rt(ex_reg_rt),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_hold(id_ex_hold), .id_ex_bubble(id_ex_bubble), .ex_mem_hold(ex_mem_hold),
    .mem_wb_bubble(mem_wb_bubble), .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
  );

  core_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_mem_memread(ex_mem_memread), .ex_reg_rt(ex_reg_rt),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_write(s_pc_write), .if_id_write(s_if_id_write), .if_id_flush(s_if_id_flush),
    .id_ex_hold(s_id_ex_hold), .id_ex_bubble(s_id_ex_bubble), .ex_mem_hold(s_ex_mem_hold),
    .mem_wb_bubble(s_mem_wb_bubble), .mem_timeout(s_mem_timeout), .stall_cnt(s_stall_cnt)
  );

  assign act = {pc_write, if_id_write, if_id_flush, id_ex_hold, id_ex_bubble,
                ex_mem_hold, mem_wb_bubble};

  typedef struct {
    logic [4:0] rs, rt, ert;
    logic       urs, urt, mr, br, req, ack;
    logic [6:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, a, e, $time);
    end
  endtask

  task automatic set_in(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic mr,
                        input logic [4:0] ert, input logic br, input logic req,
                        input logic ack);
    rst = r; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    ex_mem_memread = mr; ex_reg_rt = ert; branch_taken = br; mem_req = req; mem_ack = ack;
  endtask

  // Expected controls straight from the priority rules: reset, frozen, branch, load-use, advance
  function automatic logic [6:0] model_ctrl();
    bit lu, frz;
    lu  = ex_mem_memread && (ex_reg_rt != 0) &&
          ((id_uses_rs && id_rs == ex_reg_rt) || (id_uses_rt && id_rt == ex_reg_rt));
    frz = m_err || (!mem_ack && (m_frozen > 0 || mem_req));
    if (rst)               return C_RST;
    else if (frz)          return C_FRZ;
    else if (branch_taken) return C_BR;
    else if (lu)           return C_LU;
    else                   return C_ADV;
  endfunction

  task automatic model_edge(input logic [6:0] c);
    bit frz;
    if (rst) begin
      m_err = 0; m_frozen = 0; m_stall = 0; m_stall2 = 0;
    end else begin
      if (!c[6]) begin
        if (m_stall < 65535) m_stall++;
        if (m_stall2 < 3) m_stall2++;
      end
      frz = m_err || (!mem_ack && (m_frozen > 0 || mem_req));
      if (!m_err) begin
        if (frz) begin
          m_frozen++;
          if (m_frozen == TO) m_err = 1;
        end else begin
          m_frozen = 0;
        end
      end
    end
  endtask

  // Compare mid-cycle, then advance the model across the rising edge
  task automatic check_cycle(input string name, input logic [6:0] exp);
    logic [6:0] mc;
    @(negedge clk);
    mc = model_ctrl();
    chk({name, "_ctrl"}, 32'(act), 32'(exp));
    if (!rst) begin
      chk({name, "_timeout"}, 32'(mem_timeout), 32'(m_err));
      chk({name, "_stall_cnt"}, 32'(stall_cnt), 32'(m_stall));
      chk({name, "_stall_sat"}, 32'(s_stall_cnt), 32'(m_stall2));
    end
    @(posedge clk);
    model_edge(mc);
    #1;
  endtask

  task automatic do_reset();
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_cycle("reset", C_RST);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  vec_t tbl[10];

  initial begin
    //         rs rt ert urs urt mr br req ack exp
    tbl[0] = '{5, 0, 5, 1, 0, 1, 0, 0, 0, C_LU};
    tbl[1] = '{5, 0, 5, 1, 0, 0, 0, 0, 0, C_ADV};
    tbl[2] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, C_ADV};
    tbl[3] = '{1, 7, 7, 1, 1, 1, 0, 0, 0, C_LU};
    tbl[4] = '{1, 7, 7, 1, 0, 1, 0, 0, 0, C_ADV};
    tbl[5] = '{5, 0, 5, 1, 0, 1, 1, 0, 0, C_BR};
    tbl[6] = '{3, 4, 9, 1, 1, 0, 1, 0, 0, C_BR};
    tbl[7] = '{9, 9, 9, 1, 1, 0, 0, 0, 0, C_ADV};
    tbl[8] = '{2, 0, 2, 1, 0, 1, 0, 1, 1, C_LU};
    tbl[9] = '{2, 0, 3, 1, 0, 1, 0, 0, 1, C_ADV};

    m_err = 0; m_frozen = 0; m_stall = 0; m_stall2 = 0;
    do_reset();
    chk("after_reset_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("after_reset_timeout", 32'(mem_timeout), 32'd0);

    for (int i = 0; i < 10; i++) begin
      set_in(0, tbl[i].rs, tbl[i].rt, tbl[i].urs, tbl[i].urt, tbl[i].mr,
             tbl[i].ert, tbl[i].br, tbl[i].req, tbl[i].ack);
      check_cycle($sformatf("tbl%0d", i), tbl[i].exp);
    end
    chk("tbl_stall_total", 32'(stall_cnt), 32'd3);

    // Access acked three cycles after first sight: three frozen cycles
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) check_cycle("mem3_frz", C_FRZ);
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    check_cycle("mem3_ack_branch", C_BR);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_cycle("mem3_adv", C_ADV);
    chk("mem3_stall_cnt", 32'(stall_cnt), 32'd3);

    // No ack: TIMEOUT frozen cycles, then sticky error even on a late ack
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < TO; i++) check_cycle("to_frz", C_FRZ);
    chk("to_err", 32'(mem_timeout), 32'd1);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    check_cycle("to_late_ack", C_FRZ);
    chk("to_err_sticky", 32'(mem_timeout), 32'd1);
    chk("to_stall_cnt", 32'(stall_cnt), 32'd5);
    chk("to_stall_sat", 32'(s_stall_cnt), 32'd3);

    // Ack on the last allowed cycle recovers instead
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < TO - 1; i++) check_cycle("to_ack_frz", C_FRZ);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    check_cycle("to_ack_last", C_ADV);
    chk("to_ack_no_err", 32'(mem_timeout), 32'd0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_cycle("to_ack_run", C_ADV);

    // Reset mid-wait, then a late ack is ignored
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 2; i++) check_cycle("rw_frz", C_FRZ);
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    check_cycle("rw_rst", C_RST);
    chk("rw_stall_clr", 32'(stall_cnt), 32'd0);
    chk("rw_timeout_clr", 32'(mem_timeout), 32'd0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    check_cycle("rw_late_ack", C_ADV);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      set_in(($urandom_range(0, 31) == 0), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
             1'($urandom), 5'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
      check_cycle("rand", model_ctrl());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
